// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the LCD face arbiter: FSM state encoding, default
// timing parameters and the face codes used by the LCD1602 custom-char table.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // 1 ms of enforced idle after each write, 20 ms write watchdog, at 50 MHz
  localparam int GAP_CYC_DEF     = 50000;
  localparam int TIMEOUT_CYC_DEF = 1000000;
  localparam int FACE_W_DEF      = 3;

  // Face codes; must match the custom-char slots loaded into the LCD controller
  localparam logic [FACE_W_DEF-1:0] FACE_NEUTRAL = 3'd0;
  localparam logic [FACE_W_DEF-1:0] FACE_HAPPY   = 3'd1;
  localparam logic [FACE_W_DEF-1:0] FACE_SAD     = 3'd2;
  localparam logic [FACE_W_DEF-1:0] FACE_ANGRY   = 3'd3;
  localparam logic [FACE_W_DEF-1:0] FACE_SLEEPY  = 3'd4;
  localparam logic [FACE_W_DEF-1:0] FACE_HUNGRY  = 3'd5;
  localparam logic [FACE_W_DEF-1:0] FACE_SICK    = 3'd6;
  localparam logic [FACE_W_DEF-1:0] FACE_ALARM   = 3'd7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request found when
// scanning upward from i_ptr (wrapping at N) wins. Generic so other shared
// resources can reuse it.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic w_found;

  // Rotating priority scan starting at the pointer position
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[(int'(i_ptr) + i) % N]) begin
        w_found                      = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N] = 1'b1;
        o_idx                        = IW'((int'(i_ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/lcd_face_arbiter.sv
// Shares one LCD1602 controller between several face requesters.
//
//   state | meaning
//   IDLE  | waiting for any request; winner chosen round-robin
//   GRANT | one-cycle grant pulse, face sampled, redundancy check
//   WRITE | lcd_ready_o held until done or watchdog expiry
//   GAP   | enforced quiet time between LCD writes, requests ignored
module lcd_face_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int FACE_W      = FACE_W_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*FACE_W-1:0] face_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      lcd_ready_o,
  output logic [FACE_W-1:0]         lcd_face_o,
  input  logic                      lcd_done_i,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // One counter serves both the write watchdog and the gap timer
  localparam int CNT_W = max2(max2($clog2(TIMEOUT_CYC), $clog2(GAP_CYC)), 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [NUM_REQ-1:0] r_gnt_oh;
  logic [FACE_W-1:0]  r_face;
  logic [FACE_W-1:0]  r_last_face;
  logic               r_last_valid;
  logic               r_timeout;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PTR_W-1:0]   w_arb_idx;
  logic [FACE_W-1:0]  w_face_sel;
  logic               w_redundant;
  logic               w_tmo_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_rr (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_face_sel  = face_i[int'(r_win)*FACE_W +: FACE_W];
  assign w_redundant = r_last_valid && (w_face_sel == r_last_face);
  assign w_tmo_hit   = (r_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; done takes priority over the watchdog on the same cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (|req_i) w_next = ST_GRANT;
      ST_GRANT: w_next = w_redundant ? ST_GAP : ST_WRITE;
      ST_WRITE: if (lcd_done_i || w_tmo_hit) w_next = ST_GAP;
      ST_GAP:   if (r_cnt == GAP_LAST) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: shared counter, winner/pointer, face and last-shown face tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_win        <= '0;
      r_gnt_oh     <= '0;
      r_face       <= '0;
      r_last_face  <= '0;
      r_last_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if ((r_state != w_next) || (r_state == ST_IDLE))
        r_cnt <= '0;
      else if (r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_win    <= w_arb_idx;
            r_gnt_oh <= w_arb_gnt;
          end
        end
        ST_GRANT: begin
          r_ptr <= (r_win == PTR_LAST) ? '0 : r_win + 1'b1;
          if (!w_redundant) r_face <= w_face_sel;
        end
        ST_WRITE: begin
          if (lcd_done_i) begin
            r_last_face  <= r_face;
            r_last_valid <= 1'b1;
          end else if (w_tmo_hit) begin
            r_timeout    <= 1'b1;
            r_last_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state plus registered face/timeout
  always_comb begin
    gnt_o       = (r_state == ST_GRANT) ? r_gnt_oh : '0;
    lcd_ready_o = (r_state == ST_WRITE);
    busy_o      = (r_state != ST_IDLE);
    lcd_face_o  = r_face;
    timeout_o   = r_timeout;
  end

endmodule
